// File: rtl/time_set_pkg.sv
// Shared types, field constants and BCD step helpers for the time-set controller.
package time_set_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } ts_state_e;

    localparam logic [1:0] HOUR_TENS_MAX = 2'd2;
    localparam logic [5:0] HOUR_MAX_BCD  = 6'h23;
    localparam logic [2:0] MIN_TENS_MAX  = 3'd5;

    localparam logic [5:0] HOUR_MASK = 6'b110000;
    localparam logic [5:0] MIN_MASK  = 6'b001100;

    // Any code at or past 23 (including malformed input) wraps to 00.
    function automatic logic [5:0] bcd_hour_inc(input logic [5:0] h);
        logic [5:0] r;
        if (h >= HOUR_MAX_BCD) begin
            r = 6'h00;
        end else if (h[3:0] >= 4'd9) begin
            if (h[5:4] >= HOUR_TENS_MAX) r = 6'h00;
            else                         r = {2'(h[5:4] + 2'd1), 4'd0};
        end else begin
            r = {h[5:4], 4'(h[3:0] + 4'd1)};
        end
        return r;
    endfunction

    function automatic logic [6:0] bcd_min_inc(input logic [6:0] m);
        logic [6:0] r;
        if (m[3:0] >= 4'd9) begin
            if (m[6:4] >= MIN_TENS_MAX) r = 7'h00;
            else                        r = {3'(m[6:4] + 3'd1), 4'd0};
        end else begin
            r = {m[6:4], 4'(m[3:0] + 4'd1)};
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus down-counter debounce for one active-low push-button.
// press_o pulses for one cycle when the debounced level falls; release is silent.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], key_n_i};
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    // Counter reloads whenever the synchronized sample agrees with the stable level,
    // so only an unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = CNT_LD;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == '0) begin
                stable_d = sync_q[1];
                press_d  = ~sync_q[1];
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    assign level_o = stable_q;
    assign press_o = press_q;

endmodule

// File: rtl/time_set_controller.sv
// Time-entry controller: debounced MODE/INC keys edit HH:MM in BCD, then strobe load.
// Optional auto-repeat on a held INC key is built when TIME_SET_AUTOREPEAT_EN is defined.
//
//   state    | meaning
//   RUN      | clock running, set_* hold last edited value
//   SET_HOUR | editing hour field, HEX5..HEX4 blink
//   SET_MIN  | editing minute field, HEX3..HEX2 blink
//   COMMIT   | one-cycle load strobe, then back to RUN
module time_set_controller
    import time_set_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned BLINK_HALF      = 12500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    input  logic [5:0] cur_hour,
    input  logic [6:0] cur_min,
    output logic       editing,
    output logic       load,
    output logic [5:0] set_hour,
    output logic [6:0] set_min,
    output logic [5:0] blink_mask
);

    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LD = BLINK_W'(BLINK_HALF - 1);

    ts_state_e          state_q, state_d;
    logic [5:0]         set_hour_q, set_hour_d;
    logic [6:0]         set_min_q, set_min_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;

    logic mode_press, inc_press;
    logic mode_level, inc_level;
    logic rep_fire;
    logic inc_evt;
    logic in_field;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
        .clk_i   (clock_in),
        .rst_i   (reset),
        .key_n_i (key_mode_n),
        .level_o (mode_level),
        .press_o (mode_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
        .clk_i   (clock_in),
        .rst_i   (reset),
        .key_n_i (key_inc_n),
        .level_o (inc_level),
        .press_o (inc_press)
    );

    assign in_field = (state_q == SET_HOUR) || (state_q == SET_MIN);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q     <= RUN;
            set_hour_q  <= '0;
            set_min_q   <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            set_hour_q  <= set_hour_d;
            set_min_q   <= set_min_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mode_press) state_d = SET_HOUR;
            SET_HOUR: if (mode_press) state_d = SET_MIN;
            SET_MIN:  if (mode_press) state_d = COMMIT;
            COMMIT:   state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] REP_DELAY_LD = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RATE_LD  = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_act_q, rep_act_d;
    logic             unused_levels;

    assign unused_levels = mode_level;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            rep_cnt_q <= '0;
            rep_act_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_act_q <= rep_act_d;
        end
    end

    // Timer is armed by the press itself and dies on release or any state change.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_act_d = rep_act_q;
        rep_fire  = 1'b0;
        if (!in_field || inc_level || (state_d != state_q)) begin
            rep_cnt_d = '0;
            rep_act_d = 1'b0;
        end else if (inc_press) begin
            rep_cnt_d = REP_DELAY_LD;
            rep_act_d = 1'b1;
        end else if (rep_act_q) begin
            if (rep_cnt_q == '0) begin
                rep_fire  = 1'b1;
                rep_cnt_d = REP_RATE_LD;
            end else begin
                rep_cnt_d = rep_cnt_q - 1'b1;
            end
        end
    end
`else
    localparam int unsigned unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
    logic unused_levels;

    assign unused_levels = mode_level ^ inc_level;
    assign rep_fire      = 1'b0;
`endif

    // Mode takes priority: an increment arriving with a mode press is dropped.
    assign inc_evt = (inc_press | rep_fire) & ~mode_press;

    always_comb begin
        set_hour_d = set_hour_q;
        set_min_d  = set_min_q;
        if ((state_q == RUN) && mode_press) begin
            set_hour_d = cur_hour;
            set_min_d  = cur_min;
        end else if (inc_evt && (state_q == SET_HOUR)) begin
            set_hour_d = bcd_hour_inc(set_hour_q);
        end else if (inc_evt && (state_q == SET_MIN)) begin
            set_min_d = bcd_min_inc(set_min_q);
        end
    end

    // Phase restarts visible on every state change or increment so the new value shows at once.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if ((state_d != state_q) || (inc_evt && in_field)) begin
            blink_cnt_d = BLINK_LD;
            blink_ph_d  = 1'b0;
        end else if (in_field) begin
            if (blink_cnt_q == '0) begin
                blink_cnt_d = BLINK_LD;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q - 1'b1;
            end
        end else begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end
    end

    always_comb begin
        blink_mask = '0;
        if (blink_ph_q) begin
            if (state_q == SET_HOUR)     blink_mask = HOUR_MASK;
            else if (state_q == SET_MIN) blink_mask = MIN_MASK;
        end
    end

    assign editing  = (state_q != RUN);
    assign load     = (state_q == COMMIT);
    assign set_hour = set_hour_q;
    assign set_min  = set_min_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Randomized key-press bench for time_set_controller against an integer clock-edit model.
module tb_time_set_controller;

    localparam int DEB   = 4;
    localparam int BLK   = 8;
    localparam int RDLY  = 20;
    localparam int RRATE = 5;

    logic       clock_in = 1'b0;
    logic       reset = 1'b1;
    logic       key_mode_n = 1'b1;
    logic       key_inc_n = 1'b1;
    logic [5:0] cur_hour = '0;
    logic [6:0] cur_min = '0;
    logic       editing, load;
    logic [5:0] set_hour, blink_mask;
    logic [6:0] set_min;

    time_set_controller #(
        .DEBOUNCE_CYCLES(DEB), .BLINK_HALF(BLK), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
    ) dut (
        .clock_in(clock_in), .reset(reset), .key_mode_n(key_mode_n), .key_inc_n(key_inc_n),
        .cur_hour(cur_hour), .cur_min(cur_min), .editing(editing), .load(load),
        .set_hour(set_hour), .set_min(set_min), .blink_mask(blink_mask)
    );

    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model: mode 0=running, 1=editing hour, 2=editing minute; values as plain integers.
    int m_mode = 0, m_h = 0, m_m = 0, cur_h = 0, cur_m = 0;
    int exp_loads = 0, n_loads = 0;
    logic [5:0] ld_h = '0;
    logic [6:0] ld_m = '0;

    function automatic logic [5:0] to_bh(input int h);
        return 6'(((h / 10) << 4) | (h % 10));
    endfunction

    function automatic logic [6:0] to_bm(input int m);
        return 7'(((m / 10) << 4) | (m % 10));
    endfunction

    function automatic logic [5:0] field(input int mode);
        if (mode == 1) return 6'b110000;
        if (mode == 2) return 6'b001100;
        return 6'b000000;
    endfunction

    // Load pulses are counted and captured; any change while editing must show the field.
    initial begin
        logic [5:0] prev_h;
        logic [6:0] prev_m;
        logic       prev_load;
        int         vis;
        prev_h = '0; prev_m = '0; prev_load = 1'b0; vis = 0;
        forever begin
            @(negedge clock_in);
            if (load === 1'b1) begin
                n_loads++;
                ld_h = set_hour;
                ld_m = set_min;
                chk("load_width", prev_load, 0);
            end
            if (editing === 1'b1 && (set_hour != prev_h || set_min != prev_m)) vis = BLK;
            if (vis > 0) begin
                chk("blink_visible", blink_mask, 0);
                vis--;
            end
            prev_h = set_hour; prev_m = set_min; prev_load = load;
        end
    end

    task automatic set_cur(input int h, input int m);
        cur_h = h; cur_m = m;
        cur_hour = to_bh(h);
        cur_min  = to_bm(m);
    endtask

    task automatic check_state(input string tag);
        @(negedge clock_in);
        chk({tag, "_hour"}, set_hour, to_bh(m_h));
        chk({tag, "_min"}, set_min, to_bm(m_m));
        chk({tag, "_edit"}, editing, (m_mode != 0));
        chk({tag, "_mask"}, blink_mask & ~field(m_mode), 0);
        chk({tag, "_loads"}, n_loads, exp_loads);
    endtask

    // which: 0 mode, 1 inc, 2 both in the same cycle
    task automatic press(input int which, input string tag);
        bit committed;
        committed = 1'b0;
        if (which != 1) key_mode_n = 1'b0;
        if (which != 0) key_inc_n = 1'b0;
        repeat (DEB + 4 + $urandom_range(0, 4)) @(posedge clock_in);
        #1;
        key_mode_n = 1'b1;
        key_inc_n  = 1'b1;
        repeat (DEB + 4 + $urandom_range(0, 4)) @(posedge clock_in);
        #1;
        if (which == 1) begin
            if (m_mode == 1)      m_h = (m_h + 1) % 24;
            else if (m_mode == 2) m_m = (m_m + 1) % 60;
        end else begin
            if (m_mode == 0) begin
                m_h = cur_h; m_m = cur_m; m_mode = 1;
            end else if (m_mode == 1) begin
                m_mode = 2;
            end else begin
                m_mode = 0; exp_loads++; committed = 1'b1;
            end
        end
        check_state(tag);
        if (committed) begin
            chk({tag, "_ld_hour"}, ld_h, to_bh(m_h));
            chk({tag, "_ld_min"}, ld_m, to_bm(m_m));
        end
    endtask

    task automatic glitch(input string tag);
        bit on_mode;
        on_mode = 1'($urandom_range(0, 1));
        if (on_mode) key_mode_n = 1'b0; else key_inc_n = 1'b0;
        repeat ($urandom_range(1, DEB - 1)) @(posedge clock_in);
        #1;
        key_mode_n = 1'b1;
        key_inc_n  = 1'b1;
        repeat (DEB + 6) @(posedge clock_in);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clock_in);
        #1;
        reset = 1'b0;
        m_mode = 0; m_h = 0; m_m = 0;
        check_state(tag);
        chk({tag, "_load"}, load, 0);
        chk({tag, "_blink"}, blink_mask, 0);
    endtask

    task automatic blink_scan(input string tag);
        logic [5:0] prev, cur, f;
        int last, ntog;
        f = field(m_mode); last = -1; ntog = 0;
        @(negedge clock_in);
        prev = blink_mask;
        for (int i = 1; i < 40; i++) begin
            @(negedge clock_in);
            cur = blink_mask;
            chk({tag, "_val"}, (cur == 6'b0) || (cur == f), 1);
            if (cur != prev) begin
                if (last >= 0) chk({tag, "_period"}, i - last, BLK);
                last = i;
                ntog++;
            end
            prev = cur;
        end
        chk({tag, "_toggles"}, (ntog >= 2), 1);
    endtask

    initial begin
        repeat (3) @(posedge clock_in);
        #1;
        do_reset("reset");
        glitch("glitch_idle");

        set_cur(23, 59);
        press(0, "p2_mode"); press(1, "p2_inc"); press(0, "p2_mode");
        press(1, "p2_inc");  press(0, "p2_commit");

        set_cur(9, 9);
        press(0, "p3_mode"); press(1, "p3_inc"); press(0, "p3_mode");
        for (int i = 0; i < 51; i++) press(1, "p3_inc");
        press(0, "p3_commit");

        set_cur(17, 42);
        press(0, "sim_mode");
        blink_scan("blink_hour");
        press(2, "sim_both");
        blink_scan("blink_min");
        for (int i = 0; i < 3; i++) press(1, "rst_inc");
        do_reset("rst_mid");

`ifdef TIME_SET_AUTOREPEAT_EN
        begin
            int t_ch[$];
            logic [6:0] v_ch[$];
            logic [6:0] pm;
            int first;
            set_cur(0, 58);
            press(0, "ar_mode"); press(0, "ar_mode");
            first = -1;
            pm = set_min;
            key_inc_n = 1'b0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clock_in);
                if (set_min != pm) begin
                    t_ch.push_back(i);
                    v_ch.push_back(set_min);
                    if (first < 0) first = i;
                end
                pm = set_min;
                if (first >= 0 && i == first + 32) key_inc_n = 1'b1;
            end
            key_inc_n = 1'b1;
            chk("ar_count", t_ch.size(), 5);
            for (int k = 0; k < t_ch.size() && k < 5; k++) begin
                chk("ar_time", t_ch[k] - first, (k == 0) ? 0 : 15 + 5 * k);
                chk("ar_val", v_ch[k], to_bm((58 + 1 + k) % 60));
            end
            m_m = 3;
            check_state("ar_end");
        end
`endif

        for (int s = 0; s < 12; s++) begin
            set_cur($urandom_range(0, 23), $urandom_range(0, 59));
            press(0, "rnd_enter");
            for (int op = 0; op < 25; op++) begin
                int r;
                r = $urandom_range(0, 99);
                if (m_mode == 0) break;
                if (r < 72)      press(1, "rnd_inc");
                else if (r < 82) glitch("rnd_glitch");
                else if (r < 87) press(2, "rnd_both");
                else             press(0, "rnd_mode");
            end
            if (m_mode == 1) press(0, "rnd_tomin");
            if (m_mode == 2) press(0, "rnd_commit");
            if ($urandom_range(0, 3) == 0) do_reset("rnd_reset");
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
